interleave_acc: RTL and testbench

- Downstream consumer of the 15-stage data/valid delay line in the interleaving datapath.
- Takes a time-interleaved stream of 32-bit signed samples from NUM_CH independent channels, one sample per valid cycle, in strict round-robin channel order.
- Accumulates FRAME_LEN samples per channel.
- Emits one registered per-channel sum, with channel index and valid, each time that channel's frame completes.

---
 rtl/interleave_acc.sv | 163 ++++++++++++++++
 tb/tb_interleave_acc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleave_acc.sv
// Per-channel frame accumulator for a round-robin interleaved sample stream.
// Optional saturating arithmetic and o_sat flag: define INTERLEAVE_ACC_SAT_EN.
module interleave_acc #(
    parameter int NUM_CH    = 16,
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 40,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PASS_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_acc,
    input  logic              srdyi_acc,
    output logic [ACC_W-1:0]  o_acc,
    output logic [CH_W-1:0]   o_ch,
    output logic              srdyo_acc,
`ifdef INTERLEAVE_ACC_SAT_EN
    output logic              o_sat,
`endif
    output logic              o_frame_done
);

    logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [ACC_W-1:0]  o_acc_q, o_acc_d;
    logic [CH_W-1:0]   o_ch_q, o_ch_d;
    logic              srdyo_q, srdyo_d;
    logic              frame_done_q, frame_done_d;

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [NUM_CH-1:0] acc_wr_en;
    logic [ACC_W-1:0]  acc_rd;
    logic [ACC_W-1:0]  acc_wr;
    logic [ACC_W-1:0]  sample_ext;
    logic [ACC_W-1:0]  sum;
    logic              last_pass;
    logic              last_ch;

    assign last_pass  = (pass_cnt_q == PASS_W'(FRAME_LEN - 1));
    assign last_ch    = (ch_cnt_q == CH_W'(NUM_CH - 1));
    assign sample_ext = ACC_W'(signed'(i_acc));
    assign acc_rd     = acc_q[ch_cnt_q];

`ifdef INTERLEAVE_ACC_SAT_EN
    // One extra bit exposes signed overflow: top two bits disagree.
    logic [ACC_W:0]    sum_wide;
    logic              ovf;
    logic [NUM_CH-1:0] sat_q;
    logic              o_sat_q, o_sat_d;

    assign sum_wide = {acc_rd[ACC_W-1], acc_rd} + {sample_ext[ACC_W-1], sample_ext};
    assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        sum = sum_wide[ACC_W-1:0];
        if (ovf) begin
            sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum = acc_rd + sample_ext;
`endif

    // The last pass emits the sum and leaves the entry cleared for the next frame.
    assign acc_wr = last_pass ? '0 : sum;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_wr_en
        assign acc_wr_en[gi] = srdyi_acc && (ch_cnt_q == CH_W'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc_wr_en[i]) begin
                    acc_q[i] <= acc_wr;
                end
            end
        end
    end

`ifdef INTERLEAVE_ACC_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc_wr_en[i]) begin
                    sat_q[i] <= last_pass ? 1'b0 : (sat_q[i] | ovf);
                end
            end
        end
    end
`endif

    always_comb begin
        ch_cnt_d     = ch_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        o_acc_d      = o_acc_q;
        o_ch_d       = o_ch_q;
        srdyo_d      = 1'b0;
        frame_done_d = 1'b0;
`ifdef INTERLEAVE_ACC_SAT_EN
        o_sat_d      = o_sat_q;
`endif
        if (srdyi_acc) begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
            if (last_ch) begin
                ch_cnt_d   = '0;
                pass_cnt_d = last_pass ? '0 : pass_cnt_q + PASS_W'(1);
            end
            if (last_pass) begin
                o_acc_d      = sum;
                o_ch_d       = ch_cnt_q;
                srdyo_d      = 1'b1;
                frame_done_d = last_ch;
`ifdef INTERLEAVE_ACC_SAT_EN
                o_sat_d      = sat_q[ch_cnt_q] | ovf;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_q     <= '0;
            pass_cnt_q   <= '0;
            o_acc_q      <= '0;
            o_ch_q       <= '0;
            srdyo_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ch_cnt_q     <= ch_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            o_acc_q      <= o_acc_d;
            o_ch_q       <= o_ch_d;
            srdyo_q      <= srdyo_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef INTERLEAVE_ACC_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sat_q <= 1'b0;
        end else begin
            o_sat_q <= o_sat_d;
        end
    end

    assign o_sat = o_sat_q;
`endif

    assign o_acc        = o_acc_q;
    assign o_ch         = o_ch_q;
    assign srdyo_acc    = srdyo_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_interleave_acc.sv
// Directed bench for interleave_acc: default 16x4 instance plus a FRAME_LEN=1 pass-through instance.
module tb_interleave_acc;

    localparam int NUM_CH    = 16;
    localparam int FRAME_LEN = 4;
    localparam int ACC_W     = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      i_acc = '0;
    logic             srdyi_acc = 1'b0;
    logic [ACC_W-1:0] o_acc;
    logic [3:0]       o_ch;
    logic             srdyo_acc;
    logic             o_frame_done;

    logic [31:0]      i_acc1 = '0;
    logic             srdyi_acc1 = 1'b0;
    logic [ACC_W-1:0] o_acc1;
    logic [1:0]       o_ch1;
    logic             srdyo_acc1;
    logic             o_frame_done1;
`ifdef INTERLEAVE_ACC_SAT_EN
    logic             o_sat;
    logic             o_sat1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [ACC_W-1:0] exp_acc;
    logic [3:0]       exp_ch;
    logic             exp_v;
    logic             exp_fd;
    logic [45:0]      got;
    logic [45:0]      want;

    interleave_acc #(.NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_acc        (i_acc),
        .srdyi_acc    (srdyi_acc),
        .o_acc        (o_acc),
        .o_ch         (o_ch),
        .srdyo_acc    (srdyo_acc),
`ifdef INTERLEAVE_ACC_SAT_EN
        .o_sat        (o_sat),
`endif
        .o_frame_done (o_frame_done)
    );

    interleave_acc #(.NUM_CH(4), .FRAME_LEN(1), .ACC_W(ACC_W)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .i_acc        (i_acc1),
        .srdyi_acc    (srdyi_acc1),
        .o_acc        (o_acc1),
        .o_ch         (o_ch1),
        .srdyo_acc    (srdyo_acc1),
`ifdef INTERLEAVE_ACC_SAT_EN
        .o_sat        (o_sat1),
`endif
        .o_frame_done (o_frame_done1)
    );

    always #5 clk = ~clk;

    // Present one input cycle, sample outputs 1 ns after the capturing edge, then go idle.
    task automatic step(input logic v, input logic [31:0] d);
        @(negedge clk);
        srdyi_acc = v;
        i_acc     = d;
        @(posedge clk);
        #1;
        srdyi_acc = 1'b0;
    endtask

    task automatic step1(input logic v, input logic [31:0] d);
        @(negedge clk);
        srdyi_acc1 = v;
        i_acc1     = d;
        @(posedge clk);
        #1;
        srdyi_acc1 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({srdyo_acc, o_frame_done, o_ch, o_acc} !== 46'd0) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=0", {srdyo_acc, o_frame_done, o_ch, o_acc});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'hDEAD_BEEF);
            n_checks++;
            if ({srdyo_acc, o_frame_done, o_ch, o_acc} !== 46'd0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d] got=%h exp=0", i, {srdyo_acc, o_frame_done, o_ch, o_acc});
            end
        end
        $display("reset: outputs zero during and after reset");
    endtask

    task automatic test_passthru();
        int val;
        int k;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            val = i * 1000 - 3000;
            if (i == 5) begin
                step1(1'b0, 32'h1234_5678);
                n_checks++;
                if (srdyo_acc1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL passthru_gap got=%b exp=0", srdyo_acc1);
                end
            end
            step1(1'b1, 32'(val));
            want = {1'b1, (k % 4) == 3, 2'b00, 2'(k % 4), 40'(val)};
            got  = {srdyo_acc1, o_frame_done1, 2'b00, o_ch1, o_acc1};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL passthru[%0d] got {v,fd,ch,acc}=%h exp %h", k, got, want);
            end
            $display("passthru ch=%0d acc=%0d", k % 4, val);
            k++;
        end
    endtask

    task automatic test_ones();
        exp_acc = '0;
        exp_ch  = '0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 32'd1);
            exp_v  = (i >= 48);
            exp_fd = (i == 63);
            if (exp_v) begin
                exp_ch  = 4'(i - 48);
                exp_acc = 40'd4;
            end
            got  = {srdyo_acc, o_frame_done, o_ch, o_acc};
            want = {exp_v, exp_fd, exp_ch, exp_acc};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL ones[%0d] got {v,fd,ch,acc}=%h exp %h", i, got, want);
            end
`ifdef INTERLEAVE_ACC_SAT_EN
            if (exp_v) begin
                n_checks++;
                if (o_sat !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ones_sat[%0d] got=%b exp=0", i, o_sat);
                end
            end
`endif
            if (exp_v) $display("ones ch=%0d acc=%0d fd=%b", exp_ch, exp_acc, exp_fd);
        end
    endtask

    task automatic test_gaps();
        int k;
        for (int i = 0; i < 128; i++) begin
            k = i / 2;
            if (i % 2 == 0) begin
                step(1'b1, 32'd1);
                exp_v  = (k >= 48);
                exp_fd = (k == 63);
                if (exp_v) begin
                    exp_ch  = 4'(k - 48);
                    exp_acc = 40'd4;
                end
            end else begin
                step(1'b0, 32'hFFFF_FFFF);
                exp_v  = 1'b0;
                exp_fd = 1'b0;
            end
            got  = {srdyo_acc, o_frame_done, o_ch, o_acc};
            want = {exp_v, exp_fd, exp_ch, exp_acc};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL gaps[%0d] got {v,fd,ch,acc}=%h exp %h", i, got, want);
            end
            if (exp_v) $display("gaps ch=%0d acc=%0d", exp_ch, exp_acc);
        end
    endtask

    task automatic test_signed();
        int c;
        for (int i = 0; i < 64; i++) begin
            c = i % 16;
            step(1'b1, 32'(c - 8));
            exp_v  = (i >= 48);
            exp_fd = (i == 63);
            if (exp_v) begin
                exp_ch  = 4'(c);
                exp_acc = 40'(4 * (c - 8));
            end
            got  = {srdyo_acc, o_frame_done, o_ch, o_acc};
            want = {exp_v, exp_fd, exp_ch, exp_acc};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL signed[%0d] got {v,fd,ch,acc}=%h exp %h", i, got, want);
            end
            if (exp_v) $display("signed ch=%0d acc=%h", exp_ch, exp_acc);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [31:0] d;
        for (int i = 0; i < 128; i++) begin
            c = i % 16;
            if (i < 64) d = (c == 3) ? 32'h7FFF_FFFF : 32'd0;
            else        d = 32'd1;
            step(1'b1, d);
            exp_v  = (i % 64) >= 48;
            exp_fd = (i == 63) || (i == 127);
            if (exp_v) begin
                exp_ch = 4'(c);
                if (i < 64) exp_acc = (c == 3) ? 40'h1_FFFF_FFFC : 40'd0;
                else        exp_acc = 40'd4;
            end
            got  = {srdyo_acc, o_frame_done, o_ch, o_acc};
            want = {exp_v, exp_fd, exp_ch, exp_acc};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL b2b[%0d] got {v,fd,ch,acc}=%h exp %h", i, got, want);
            end
            if (exp_v) $display("b2b frame=%0d ch=%0d acc=%h", i / 64, exp_ch, exp_acc);
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 32'd5);
            n_checks++;
            if ({srdyo_acc, o_frame_done, o_ch, o_acc} !== {2'b00, exp_ch, exp_acc}) begin
                n_fail++;
                $display("FAIL midrst_pre[%0d] got=%h exp=%h", i,
                         {srdyo_acc, o_frame_done, o_ch, o_acc}, {2'b00, exp_ch, exp_acc});
            end
        end
        // Reset lands between edges: outputs must clear without a clock.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({srdyo_acc, o_frame_done, o_ch, o_acc} !== 46'd0) begin
            n_fail++;
            $display("FAIL midrst_async got=%h exp=0", {srdyo_acc, o_frame_done, o_ch, o_acc});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_acc = '0;
        exp_ch  = '0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 32'd2);
            exp_v  = (i >= 48);
            exp_fd = (i == 63);
            if (exp_v) begin
                exp_ch  = 4'(i - 48);
                exp_acc = 40'd8;
            end
            got  = {srdyo_acc, o_frame_done, o_ch, o_acc};
            want = {exp_v, exp_fd, exp_ch, exp_acc};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL midrst[%0d] got {v,fd,ch,acc}=%h exp %h", i, got, want);
            end
            if (exp_v) $display("midrst ch=%0d acc=%0d", exp_ch, exp_acc);
        end
    endtask

    initial begin
        exp_acc = '0;
        exp_ch  = '0;
        exp_v   = 1'b0;
        exp_fd  = 1'b0;
        test_reset();
        test_passthru();
        test_ones();
        test_gaps();
        test_signed();
        test_back_to_back();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
